// File: rtl/adc_pkg.sv
// Shared types, widths and helpers for the ADC capture/averaging path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;

  // Widths of the default build (12-bit AD9226, averaging up to 2^4 samples).
  localparam int ADC_DATA_W       = 12;
  localparam int ADC_AVG_MAX_LOG2 = 4;
  localparam int ACC_W            = ADC_DATA_W + ADC_AVG_MAX_LOG2;
  localparam int CNT_W            = ADC_AVG_MAX_LOG2;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;

  // Offset binary <-> two's complement is a flip of the word MSB. The word
  // travels zero-extended in 32 bits so callers with any width <= 32 can use it.
  function automatic logic [31:0] offs_to_twos(input logic [31:0] word, input int width);
    return word ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/adc_capture_avg_if.sv
// Valid/ready stream carrying averaged ADC words towards the packetiser.
// Latency: none (wires only).
// Backpressure: a word moves only on a cycle where m_valid and m_ready are both high.
//  m_data  : NUM_CH*DATA_W result word, ch0 in LSBs
//  m_valid : producer has a word
//  m_ready : consumer accepts the word
interface adc_capture_avg_if #(
  parameter int W = 12
);
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy output.
// Latency: a written word is visible on rd_dat the cycle after the write edge.
// Backpressure: writes when full are ignored unless a read happens on the same edge.
//  clk, rst_n      : clock, async active-low reset (pointers and level only)
//  wr_en, wr_dat   : write request and data
//  rd_en, rd_dat   : read (pop) request, head word (0 when empty)
//  level/full/empty: occupancy status
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign rd_fire = rd_en && !empty;
  // A read on the same edge frees the slot, so a full FIFO still takes the write.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign level   = level_q;
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); level tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_avg.sv
// ADC capture: input register chain, per-channel block averaging, format conversion, output FIFO.
// Latency: with n=0 a sample on data_in before edge k is on m_data after edge k+SYNC_STAGES+1.
// Backpressure: m_ready stalls the FIFO only; capture never stalls, results arriving at a full
//  FIFO are dropped and flagged in sticky overflow.
//  sys_clk, reset_n : clock, async active-low reset
//  data_in          : NUM_CH offset-binary ADC words, ch0 in LSBs
//  enable           : capture enable; low discards the block in progress
//  avg_log2         : averaging exponent n (clamped to AVG_MAX_LOG2)
//  fmt_twos         : 1 = two's complement output, 0 = offset binary
//  m_if             : valid/ready result stream (head of FIFO, 0 when empty)
//  fill_level       : FIFO occupancy
//  overflow         : sticky drop flag, cleared by clr_overflow pulse
module adc_capture_avg
  import adc_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int NUM_CH       = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int AVG_MAX_LOG2 = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            sys_clk,
  input  logic                            reset_n,
  input  logic [NUM_CH*DATA_W-1:0]        data_in,
  input  logic                            enable,
  input  logic [$clog2(AVG_MAX_LOG2+1)-1:0] avg_log2,
  input  logic                            fmt_twos,
  adc_capture_avg_if.master               m_if,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  localparam int WORD_W   = NUM_CH * DATA_W;
  localparam int ACC_BITS = DATA_W + AVG_MAX_LOG2;
  localparam int CNT_BITS = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;
  localparam int LOG_BITS = $clog2(AVG_MAX_LOG2 + 1);

  // ---------------------------------------------------------------- input chain
  // Free-running: the chain keeps loading even while capture is disabled.
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic [WORD_W-1:0] q;
    logic [WORD_W-1:0] d;
    if (g == 0) begin : g_head
      assign d = data_in;
    end else begin : g_tail
      assign d = g_sync[g-1].q;
    end
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

  logic [WORD_W-1:0] sample;
  assign sample = g_sync[SYNC_STAGES-1].q;

  // ---------------------------------------------------------------- block control
  logic [CNT_BITS-1:0] cnt_q;
  logic [LOG_BITS-1:0] n_q;
  logic [LOG_BITS-1:0] n_in;
  logic [LOG_BITS-1:0] n_cur;
  logic                blk_last;

  assign n_in  = (avg_log2 > LOG_BITS'(AVG_MAX_LOG2)) ? LOG_BITS'(AVG_MAX_LOG2) : avg_log2;
  // The exponent is taken fresh on the first sample of a block and held until
  // the block closes, so a mid-block change only affects the next block.
  assign n_cur = (cnt_q == '0) ? n_in : n_q;
  assign blk_last = (cnt_q == CNT_BITS'((32'd1 << n_cur) - 32'd1));

  // ---------------------------------------------------------------- per-channel averaging
  logic [WORD_W-1:0] res_dat;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_BITS-1:0] acc_q;
    logic [ACC_BITS-1:0] sum;
    logic [DATA_W-1:0]   avg;

    // The sample of the closing edge is folded in combinationally so the block
    // needs exactly 2^n edges, then the sum is truncated by the shift.
    assign sum = acc_q + ACC_BITS'(sample[c*DATA_W +: DATA_W]);
    assign avg = DATA_W'(sum >> n_cur);
    assign res_dat[c*DATA_W +: DATA_W] =
      fmt_twos ? DATA_W'(offs_to_twos(32'(avg), DATA_W)) : avg;

    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q <= '0;
      end else if (!enable || blk_last) begin
        acc_q <= '0;
      end else begin
        acc_q <= sum;
      end
    end
  end

  // One register stage between the averager and the FIFO write port.
  logic              push_q;
  logic [WORD_W-1:0] push_dat_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      n_q        <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else if (!enable) begin
      cnt_q  <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= blk_last;
      if (cnt_q == '0) begin
        n_q <= n_in;
      end
      if (blk_last) begin
        cnt_q      <= '0;
        push_dat_q <= res_dat;
      end else begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
    end
  end

  // ---------------------------------------------------------------- output FIFO
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;
  logic [WORD_W-1:0] fifo_dat;

  assign pop  = !fifo_empty && m_if.m_ready;
  assign drop = push_q && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (reset_n),
    .wr_en  (push_q),
    .wr_dat (push_dat_q),
    .rd_en  (pop),
    .rd_dat (fifo_dat),
    .level  (fill_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_if.m_data  = fifo_dat;
  assign m_if.m_valid = !fifo_empty;

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_avg.sv
// Directed, table-driven bench for adc_capture_avg in its default configuration.
module tb_adc_capture_avg;
  import adc_pkg::*;

  localparam int S = 2;

  logic        sys_clk;
  logic        reset_n;
  adc_sample_t data_in;
  logic        enable;
  logic [2:0]  avg_log2;
  logic        fmt_twos;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        clr_overflow;

  adc_capture_avg_if #(.W(12)) m_if ();

  adc_capture_avg #(
    .DATA_W       (12),
    .NUM_CH       (1),
    .SYNC_STAGES  (S),
    .AVG_MAX_LOG2 (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .enable       (enable),
    .avg_log2     (avg_log2),
    .fmt_twos     (fmt_twos),
    .m_if         (m_if),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  n;
    logic        fmt;
    adc_sample_t a;
    adc_sample_t b;
    adc_sample_t exp;
  } vec_t;

  vec_t        vecs [10];
  adc_sample_t seq  [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Feeds seq[0..cnt-1] so that enable is high on exactly the edges where
  // those samples leave the input chain.
  task automatic feed(input int cnt, input int n0, input int n1);
    for (int s = 0; s < cnt + S; s++) begin
      data_in  = (s < cnt) ? seq[s] : 12'h000;
      enable   = (s >= S);
      avg_log2 = (s <= S) ? 3'(n0) : 3'(n1);
      tick();
    end
  endtask

  // Drops enable and lets a registered push land in the FIFO.
  task automatic settle();
    enable  = 1'b0;
    data_in = 12'h000;
    tick();
  endtask

  task automatic pop1();
    m_if.m_ready = 1'b1;
    tick();
    m_if.m_ready = 1'b0;
  endtask

  initial begin
    int nb;
    logic ev;
    logic [11:0] ed;

    vecs[0] = '{3'd0, 1'b0, 12'h123, 12'h123, 12'h123};
    vecs[1] = '{3'd0, 1'b1, 12'h123, 12'h123, 12'h923};
    vecs[2] = '{3'd1, 1'b0, 12'd100, 12'd103, 12'd101};
    vecs[3] = '{3'd2, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF};
    vecs[4] = '{3'd2, 1'b1, 12'hFFF, 12'hFFF, 12'h7FF};
    vecs[5] = '{3'd3, 1'b0, 12'h000, 12'h001, 12'h000};
    vecs[6] = '{3'd4, 1'b0, 12'h800, 12'h801, 12'h800};
    vecs[7] = '{3'd7, 1'b0, 12'd10,  12'd13,  12'd11};
    vecs[8] = '{3'd4, 1'b1, 12'h000, 12'h000, 12'h800};
    vecs[9] = '{3'd1, 1'b0, 12'hFFF, 12'hFFE, 12'hFFE};

    reset_n      = 1'b0;
    data_in      = '0;
    enable       = 1'b0;
    avg_log2     = 3'd0;
    fmt_twos     = 1'b0;
    clr_overflow = 1'b0;
    m_if.m_ready = 1'b0;
    #2;
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_data",  32'(m_if.m_data),  32'd0);
    check("rst_level", 32'(fill_level),   32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Ramp 0..9, n=0, consumer always ready: word i appears after edge i+S+2.
    m_if.m_ready = 1'b1;
    for (int e = 0; e < 15; e++) begin
      data_in = (e < 10) ? 12'(e) : 12'h000;
      enable  = (e >= S) && (e < 10 + S);
      tick();
      ev = (e + 1 >= S + 2) && (e + 1 <= 9 + S + 2);
      ed = ev ? 12'(e + 1 - S - 2) : 12'h000;
      check("ramp_valid", 32'(m_if.m_valid), 32'(ev));
      check("ramp_data",  32'(m_if.m_data),  32'(ed));
    end
    m_if.m_ready = 1'b0;
    enable = 1'b0;
    tick();

    // Table: one block per record, samples alternate a,b.
    for (int v = 0; v < 10; v++) begin
      nb = 1 << ((int'(vecs[v].n) > CNT_W) ? CNT_W : int'(vecs[v].n));
      for (int i = 0; i < nb; i++) begin
        seq[i] = (i % 2 == 0) ? vecs[v].a : vecs[v].b;
      end
      fmt_twos = vecs[v].fmt;
      feed(nb, int'(vecs[v].n), int'(vecs[v].n));
      settle();
      check($sformatf("vec%0d_valid", v), 32'(m_if.m_valid), 32'd1);
      check($sformatf("vec%0d_data", v),  32'(m_if.m_data),  32'(vecs[v].exp));
      pop1();
      check($sformatf("vec%0d_empty", v), 32'(m_if.m_valid), 32'd0);
    end
    fmt_twos = 1'b0;

    // n=2 with 100..103 repeating: two pushes of 101.
    for (int i = 0; i < 8; i++) seq[i] = 12'(100 + (i % 4));
    feed(8, 2, 2);
    settle();
    check("avg4_level", 32'(fill_level),  32'd2);
    check("avg4_data0", 32'(m_if.m_data), 32'd101);
    pop1();
    check("avg4_data1", 32'(m_if.m_data), 32'd101);
    pop1();
    check("avg4_empty", 32'(m_if.m_valid), 32'd0);

    // Overfill: 10 samples into 8 entries with no consumer.
    for (int i = 0; i < 10; i++) seq[i] = 12'(16'h10 + i);
    feed(10, 0, 0);
    settle();
    check("ovf_level", 32'(fill_level),  32'd8);
    check("ovf_set",   32'(overflow),    32'd1);
    check("ovf_head",  32'(m_if.m_data), 32'h10);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr",       32'(overflow),   32'd0);
    check("ovf_clr_level", 32'(fill_level), 32'd8);

    // Full FIFO with push and pop on the same edges: level holds, no drop.
    for (int s = 0; s <= S + 6; s++) begin
      data_in      = (s < 6) ? 12'(16'h40 + s) : 12'h000;
      enable       = (s >= S) && (s < 6 + S);
      m_if.m_ready = (s >= S + 1) && (s <= S + 6);
      if (m_if.m_ready) check("full_pop_data", 32'(m_if.m_data), 32'(16'h10 + s - S - 1));
      tick();
      if ((s >= S + 1) && (s <= S + 6)) begin
        check("full_level", 32'(fill_level), 32'd8);
        check("full_ovf",   32'(overflow),   32'd0);
      end
    end
    m_if.m_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("drain_data", 32'(m_if.m_data), (j < 2) ? 32'(16'h16 + j) : 32'(16'h40 + j - 2));
      pop1();
    end
    check("drain_valid", 32'(m_if.m_valid), 32'd0);
    check("drain_data0", 32'(m_if.m_data),  32'd0);
    check("drain_level", 32'(fill_level),   32'd0);

    // Partial block discarded by enable drop, then a fresh n=3 block.
    for (int i = 0; i < 5; i++) seq[i] = 12'hFA0;
    feed(5, 3, 3);
    settle();
    tick();
    check("partial_level", 32'(fill_level), 32'd0);
    for (int i = 0; i < 8; i++) seq[i] = 12'd8;
    feed(8, 3, 3);
    settle();
    check("fresh_level", 32'(fill_level),  32'd1);
    check("fresh_data",  32'(m_if.m_data), 32'd8);
    pop1();

    // Exponent change one sample into a block applies to the next block only.
    seq[0] = 12'd10; seq[1] = 12'd20; seq[2] = 12'd30;
    seq[3] = 12'd40; seq[4] = 12'd50; seq[5] = 12'd60;
    feed(6, 1, 2);
    settle();
    check("nchg_level", 32'(fill_level),  32'd2);
    check("nchg_data0", 32'(m_if.m_data), 32'd15);
    pop1();
    check("nchg_data1", 32'(m_if.m_data), 32'd45);
    pop1();
    check("nchg_empty", 32'(m_if.m_valid), 32'd0);

    // Reset with 5 entries queued, overflow set and a block in progress.
    for (int i = 0; i < 9; i++) seq[i] = 12'(16'h20 + i);
    feed(9, 0, 0);
    settle();
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    pop1();
    pop1();
    pop1();
    check("pre_rst_level", 32'(fill_level), 32'd5);
    for (int i = 0; i < 3; i++) seq[i] = 12'h111;
    feed(3, 3, 3);
    reset_n = 1'b0;
    #2;
    check("arst_valid", 32'(m_if.m_valid), 32'd0);
    check("arst_data",  32'(m_if.m_data),  32'd0);
    check("arst_level", 32'(fill_level),   32'd0);
    check("arst_ovf",   32'(overflow),     32'd0);
    enable = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    seq[0] = 12'd300;
    seq[1] = 12'd302;
    feed(2, 1, 1);
    settle();
    check("post_rst_level", 32'(fill_level),  32'd1);
    check("post_rst_data",  32'(m_if.m_data), 32'd301);
    check("post_rst_ovf",   32'(overflow),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
